// File: rtl/reg_bus_guard.sv
// rtl/reg_bus_guard.sv - single-outstanding register bus guard with window decode and timeout abort
`timescale 1ns/1ps

package reg_bus_guard_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module reg_bus_guard #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH:0]    ADDR_SPAN  = 'h1000,
    parameter int unsigned            TIMEOUT    = 64,
    parameter logic [DATA_WIDTH-1:0]  ERR_DATA   = 'hBADCAB1E,
    parameter type                    reg_req_t  = reg_bus_guard_pkg::reg_req_t,
    parameter type                    reg_rsp_t  = reg_bus_guard_pkg::reg_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  reg_req_t    up_req_i,
    output reg_rsp_t    up_rsp_o,
    output reg_req_t    dn_req_o,
    input  reg_rsp_t    dn_rsp_i,
    output logic        decerr_o,
    output logic        timeout_o,
    output logic [15:0] timeout_cnt_o,
    output logic        busy_o
);

    localparam int unsigned OFF_W = $clog2(DATA_WIDTH / 8);
    localparam int unsigned CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        DERR,
        TERM
    } state_e;

    state_e          state_q, state_d;
    reg_req_t        req_q, req_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [15:0]     tcnt_q, tcnt_d;

    logic [ADDR_WIDTH:0] addr_ext;
    logic [ADDR_WIDTH:0] win_lo;
    logic [ADDR_WIDTH:0] win_hi;
    logic                in_win;
    logic                misalign;

    // Window compare is one bit wider so BASE_ADDR+ADDR_SPAN cannot wrap.
    assign addr_ext = {1'b0, up_req_i.addr};
    assign win_lo   = {1'b0, BASE_ADDR};
    assign win_hi   = win_lo + ADDR_SPAN;
    assign in_win   = (addr_ext >= win_lo) && (addr_ext < win_hi);
    assign misalign = |up_req_i.addr[OFF_W-1:0];

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        wait_d         = wait_q;
        tcnt_d         = tcnt_q;
        dn_req_o       = req_q;
        dn_req_o.valid = 1'b0;
        up_rsp_o       = '0;
        decerr_o       = 1'b0;
        timeout_o      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (up_req_i.valid) begin
                    req_d   = up_req_i;
                    wait_d  = '0;
                    state_d = (!in_win || misalign) ? DERR : FWD;
                end
            end
            FWD: begin
                dn_req_o.valid = 1'b1;
                // A ready arriving on the last wait cycle still completes normally.
                if (dn_rsp_i.ready) begin
                    up_rsp_o.ready = 1'b1;
                    up_rsp_o.error = dn_rsp_i.error;
                    up_rsp_o.rdata = dn_rsp_i.rdata;
                    state_d        = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = TERM;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DERR: begin
                up_rsp_o.ready = 1'b1;
                up_rsp_o.error = 1'b1;
                up_rsp_o.rdata = ERR_DATA;
                decerr_o       = 1'b1;
                state_d        = IDLE;
            end
            TERM: begin
                up_rsp_o.ready = 1'b1;
                up_rsp_o.error = 1'b1;
                up_rsp_o.rdata = ERR_DATA;
                timeout_o      = 1'b1;
                if (tcnt_q != 16'hFFFF) begin
                    tcnt_d = tcnt_q + 16'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            wait_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign timeout_cnt_o = tcnt_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_reg_bus_guard.sv
// tb/tb_reg_bus_guard.sv - directed self-checking bench for reg_bus_guard
`timescale 1ns/1ps

module tb_reg_bus_guard;
    import reg_bus_guard_pkg::*;

    localparam logic [31:0] ERR = 32'hBADCAB1E;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_req_t    up_req, dn_req, s_up_req, s_dn_req;
    reg_rsp_t    up_rsp, dn_rsp, s_up_rsp, s_dn_rsp;
    logic        decerr, timeout, busy;
    logic        s_decerr, s_timeout, s_busy;
    logic [15:0] tcnt, s_tcnt;
    logic [5:0]  flags;

    int total = 0;
    int bad   = 0;

    assign flags = {busy, dn_req.valid, up_rsp.ready, up_rsp.error, decerr, timeout};

    reg_bus_guard #(
        .BASE_ADDR(32'h4000),
        .ADDR_SPAN(33'h1000),
        .TIMEOUT  (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .up_req_i     (up_req),
        .up_rsp_o     (up_rsp),
        .dn_req_o     (dn_req),
        .dn_rsp_i     (dn_rsp),
        .decerr_o     (decerr),
        .timeout_o    (timeout),
        .timeout_cnt_o(tcnt),
        .busy_o       (busy)
    );

    reg_bus_guard #(
        .TIMEOUT(1)
    ) dut_sat (
        .clk_i        (clk),
        .rst_i        (rst),
        .up_req_i     (s_up_req),
        .up_rsp_o     (s_up_rsp),
        .dn_req_o     (s_dn_req),
        .dn_rsp_i     (s_dn_rsp),
        .decerr_o     (s_decerr),
        .timeout_o    (s_timeout),
        .timeout_cnt_o(s_tcnt),
        .busy_o       (s_busy)
    );

    function automatic reg_req_t mk_req(input logic [31:0] a, input logic w, input logic [31:0] d);
        return '{addr: a, write: w, wdata: d, wstrb: 4'hF, valid: 1'b1};
    endfunction

    function automatic reg_rsp_t mk_rsp(input logic [31:0] d, input logic e);
        return '{rdata: d, error: e, ready: 1'b1};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        up_req = '0; dn_rsp = '0; s_up_req = '0; s_dn_rsp = '0;
        tick; tick;
        rst = 1'b0;
        settle;
        total++; if (flags !== 6'b000000) begin bad++; $display("FAIL reset_flags got=%b want=%b", flags, 6'b000000); end
        total++; if (up_rsp.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=%h", up_rsp.rdata, 32'h0); end
        total++; if (tcnt !== 16'h0) begin bad++; $display("FAIL reset_tcnt got=%h want=%h", tcnt, 16'h0); end
    endtask

    task automatic test_read;
        tick;
        up_req = mk_req(32'h4010, 1'b0, 32'h0); dn_rsp = '0;
        settle;
        total++; if (flags !== 6'b000000) begin bad++; $display("FAIL read_idle got=%b want=%b", flags, 6'b000000); end
        for (int i = 0; i < 3; i++) begin
            tick; settle;
            total++; if (flags !== 6'b110000) begin bad++; $display("FAIL read_wait%0d got=%b want=%b", i, flags, 6'b110000); end
            total++; if (dn_req.addr !== 32'h4010) begin bad++; $display("FAIL read_dn_addr got=%h want=%h", dn_req.addr, 32'h4010); end
        end
        tick;
        dn_rsp = mk_rsp(32'h1234, 1'b0);
        settle;
        total++; if (flags !== 6'b111000) begin bad++; $display("FAIL read_done got=%b want=%b", flags, 6'b111000); end
        total++; if (up_rsp.rdata !== 32'h1234) begin bad++; $display("FAIL read_rdata got=%h want=%h", up_rsp.rdata, 32'h1234); end
        tick;
        up_req = '0; dn_rsp = '0;
        settle;
        total++; if (flags !== 6'b000000) begin bad++; $display("FAIL read_after got=%b want=%b", flags, 6'b000000); end
        total++; if (tcnt !== 16'h0) begin bad++; $display("FAIL read_tcnt got=%h want=%h", tcnt, 16'h0); end
    endtask

    task automatic test_decerr;
        logic [31:0] addrs [3];
        addrs = '{32'h5000, 32'h4002, 32'h3FFC};
        for (int k = 0; k < 3; k++) begin
            tick;
            up_req = mk_req(addrs[k], 1'b1, 32'hDEAD0000);
            settle;
            total++; if (flags !== 6'b000000) begin bad++; $display("FAIL decerr_idle%0d got=%b want=%b", k, flags, 6'b000000); end
            tick; settle;
            total++; if (flags !== 6'b101110) begin bad++; $display("FAIL decerr_rsp%0d got=%b want=%b", k, flags, 6'b101110); end
            total++; if (up_rsp.rdata !== ERR) begin bad++; $display("FAIL decerr_rdata%0d got=%h want=%h", k, up_rsp.rdata, ERR); end
            tick;
            up_req = '0;
            settle;
            total++; if (flags !== 6'b000000) begin bad++; $display("FAIL decerr_after%0d got=%b want=%b", k, flags, 6'b000000); end
        end
    endtask

    task automatic test_timeout;
        int n;
        tick;
        up_req = mk_req(32'h4020, 1'b0, 32'h0); dn_rsp = '0;
        settle;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick; settle;
            if (dn_req.valid) n++;
            else break;
        end
        total++; if (n !== 4) begin bad++; $display("FAIL timeout_dn_cycles got=%0d want=%0d", n, 4); end
        dn_rsp = mk_rsp(32'h55, 1'b0);
        settle;
        total++; if (flags !== 6'b101101) begin bad++; $display("FAIL timeout_term got=%b want=%b", flags, 6'b101101); end
        total++; if (up_rsp.rdata !== ERR) begin bad++; $display("FAIL timeout_rdata got=%h want=%h", up_rsp.rdata, ERR); end
        total++; if (tcnt !== 16'h0) begin bad++; $display("FAIL timeout_tcnt_term got=%h want=%h", tcnt, 16'h0); end
        tick;
        up_req = '0; dn_rsp = '0;
        settle;
        total++; if (flags !== 6'b000000) begin bad++; $display("FAIL timeout_after got=%b want=%b", flags, 6'b000000); end
        total++; if (tcnt !== 16'h1) begin bad++; $display("FAIL timeout_tcnt got=%h want=%h", tcnt, 16'h1); end
    endtask

    task automatic test_reset_mid;
        tick;
        up_req = mk_req(32'h4030, 1'b0, 32'h0); dn_rsp = '0;
        settle;
        tick; settle;
        total++; if (flags !== 6'b110000) begin bad++; $display("FAIL rstmid_fwd got=%b want=%b", flags, 6'b110000); end
        rst = 1'b1;
        tick;
        rst = 1'b0; up_req = '0;
        settle;
        total++; if (flags !== 6'b000000) begin bad++; $display("FAIL rstmid_flags got=%b want=%b", flags, 6'b000000); end
        total++; if (tcnt !== 16'h0) begin bad++; $display("FAIL rstmid_tcnt got=%h want=%h", tcnt, 16'h0); end
        tick;
        up_req = mk_req(32'h4030, 1'b0, 32'h0);
        settle;
        tick;
        dn_rsp = mk_rsp(32'hCAFE, 1'b0);
        settle;
        total++; if (flags !== 6'b111000) begin bad++; $display("FAIL rstmid_reissue got=%b want=%b", flags, 6'b111000); end
        total++; if (up_rsp.rdata !== 32'hCAFE) begin bad++; $display("FAIL rstmid_rdata got=%h want=%h", up_rsp.rdata, 32'hCAFE); end
        tick;
        up_req = '0; dn_rsp = '0;
        settle;
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic        wrs   [3];
        logic [31:0] wds   [3];
        logic [31:0] rds   [3];
        int cyc;
        int last;
        addrs = '{32'h4000, 32'h4FFC, 32'h4008};
        wrs   = '{1'b0, 1'b1, 1'b0};
        wds   = '{32'h0, 32'hA5A5A5A5, 32'h0};
        rds   = '{32'h11, 32'h22, 32'h33};
        cyc = 0; last = 0;
        tick;
        up_req = mk_req(addrs[0], wrs[0], wds[0]);
        dn_rsp = mk_rsp(32'h99, 1'b0);
        settle;
        total++; if (up_rsp.ready !== 1'b0) begin bad++; $display("FAIL b2b_idle_ready got=%b want=%b", up_rsp.ready, 1'b0); end
        for (int k = 0; k < 3; k++) begin
            tick; cyc++;
            dn_rsp = mk_rsp(rds[k], 1'b0);
            settle;
            total++; if (flags !== 6'b111000) begin bad++; $display("FAIL b2b_rsp%0d got=%b want=%b", k, flags, 6'b111000); end
            total++; if (up_rsp.rdata !== rds[k]) begin bad++; $display("FAIL b2b_rdata%0d got=%h want=%h", k, up_rsp.rdata, rds[k]); end
            total++;
            if ({dn_req.addr, dn_req.write, dn_req.wdata} !== {addrs[k], wrs[k], wds[k]}) begin
                bad++;
                $display("FAIL b2b_dnreq%0d got=%h/%b/%h want=%h/%b/%h", k,
                         dn_req.addr, dn_req.write, dn_req.wdata, addrs[k], wrs[k], wds[k]);
            end
            if (k > 0) begin
                total++; if (cyc - last !== 2) begin bad++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", k, cyc - last, 2); end
            end
            last = cyc;
            tick; cyc++;
            if (k < 2) up_req = mk_req(addrs[k+1], wrs[k+1], wds[k+1]);
            else       up_req = '0;
            settle;
            total++; if (flags !== 6'b000000) begin bad++; $display("FAIL b2b_gap%0d got=%b want=%b", k, flags, 6'b000000); end
        end
        dn_rsp = '0;
    endtask

    task automatic test_saturation;
        int n;
        logic [15:0] exp;
        s_up_req = mk_req(32'h0, 1'b0, 32'h0);
        s_dn_rsp = '0;
        for (int i = 0; i <= 65536; i++) begin
            n = 0;
            while (!s_timeout && n < 8) begin
                tick;
                n++;
            end
            if (!s_timeout) begin
                total++; bad++;
                $display("FAIL sat_no_timeout at=%0d got=%b want=%b", i, s_timeout, 1'b1);
                break;
            end
            if (i < 3 || i >= 65534) begin
                exp = (i > 65535) ? 16'hFFFF : 16'(i);
                total++; if (s_tcnt !== exp) begin bad++; $display("FAIL sat_tcnt%0d got=%h want=%h", i, s_tcnt, exp); end
            end
            tick;
        end
        s_up_req = '0;
        tick; tick; tick;
        total++; if (s_tcnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=%h", s_tcnt, 16'hFFFF); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_decerr;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        test_saturation;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
